// File: rtl/bram_xfer_scheduler_pkg.sv
// Shared types for the BRAM transfer scheduler: FSM states, descriptor layout and line geometry.
package bram_xfer_scheduler_pkg;

  localparam int LINE_ADDR_W = 12;
  localparam int LINE_BEATS  = 36;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    LOAD,
    RUN,
    DONE
  } state_t;

  typedef struct packed {
    logic                   rw;
    logic [LINE_ADDR_W-1:0] start_line;
    logic [LINE_ADDR_W-1:0] end_line;
  } desc_t;

  function automatic logic line_range_bad(input desc_t d);
    return d.end_line < d.start_line;
  endfunction

endpackage

// File: rtl/bram_xfer_scheduler_desc_fifo.sv
// Descriptor queue: synchronous FIFO, read data visible combinationally at the head.
// Push is refused while full; flush empties the queue but keeps a push made in the same cycle.
module bram_desc_fifo
  import bram_xfer_scheduler_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  desc_t wr_desc,
  input  logic  pop,
  input  logic  flush,
  output desc_t rd_desc,
  output logic  full,
  output logic  empty
);

  localparam int PTR_W = $clog2(DEPTH);

  desc_t          mem [DEPTH];
  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;
  logic           do_push;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign rd_desc = mem[rd_ptr[PTR_W-1:0]];
  assign do_push = push && !full;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[PTR_W-1:0]] <= wr_desc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (flush) begin
        rd_ptr <= wr_ptr;
      end else if (pop && !empty) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bram_xfer_scheduler.sv
// Sequences queued BRAM transfer descriptors into the AXIS-BRAM adapter and reports one completion each.
// Push to reload is 3 cycles; desc_ready drops when the queue is full, completions wait for cmp_ready.
module bram_xfer_scheduler
  import bram_xfer_scheduler_pkg::*;
#(
  parameter int ADDR_W         = LINE_ADDR_W,
  parameter int BEATS_PER_LINE = LINE_BEATS,
  parameter int FIFO_DEPTH     = 4,
  parameter int CNT_W          = 18
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              desc_valid,
  output logic              desc_ready,
  input  logic              desc_rw,
  input  logic [ADDR_W-1:0] desc_start,
  input  logic [ADDR_W-1:0] desc_end,
  output logic              ctrl_rw,
  output logic              ctrl_reload,
  output logic [ADDR_W-1:0] ctrl_start_addr,
  output logic [ADDR_W-1:0] ctrl_end_addr,
  input  logic              beat,
  input  logic              beat_last,
  input  logic              abort,
  output logic              cmp_valid,
  input  logic              cmp_ready,
  output logic              cmp_rw,
  output logic [CNT_W-1:0]  cmp_beats,
  output logic              cmp_err,
  output logic              busy
);

  localparam logic [CNT_W-1:0] BPL = CNT_W'(BEATS_PER_LINE);

  state_t           state;
  desc_t            in_desc;
  desc_t            head;
  desc_t            cur;
  logic             q_full;
  logic             q_empty;
  logic             q_pop;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] exp_beats;
  logic [CNT_W-1:0] head_beats;

  // ADDR_W is expected to match the descriptor field width in the package.
  assign in_desc    = '{rw: desc_rw, start_line: desc_start, end_line: desc_end};
  assign desc_ready = !q_full;
  assign q_pop      = (state == IDLE) && !q_empty && !abort;
  assign busy       = (state != IDLE) || !q_empty;
  assign cnt_inc    = cnt + 1'b1;
  assign head_beats = (CNT_W'(head.end_line) - CNT_W'(head.start_line) + CNT_W'(1)) * BPL;

  bram_desc_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (aclk),
    .rst     (areset),
    .push    (desc_valid),
    .wr_desc (in_desc),
    .pop     (q_pop),
    .flush   (abort),
    .rd_desc (head),
    .full    (q_full),
    .empty   (q_empty)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state           <= IDLE;
      cur             <= '0;
      cnt             <= '0;
      exp_beats       <= '0;
      ctrl_rw         <= 1'b1;
      ctrl_reload     <= 1'b0;
      ctrl_start_addr <= '0;
      ctrl_end_addr   <= '0;
      cmp_valid       <= 1'b0;
      cmp_rw          <= 1'b0;
      cmp_beats       <= '0;
      cmp_err         <= 1'b0;
    end else begin
      ctrl_reload <= 1'b0;
      case (state)
        IDLE: begin
          if (q_pop) begin
            cur       <= head;
            exp_beats <= head_beats;
            state     <= CHECK;
          end
        end
        CHECK: begin
          if (abort) begin
            state <= IDLE;
          end else if (line_range_bad(cur)) begin
            cmp_valid <= 1'b1;
            cmp_rw    <= cur.rw;
            cmp_beats <= '0;
            cmp_err   <= 1'b1;
            state     <= DONE;
          end else begin
            ctrl_rw         <= cur.rw;
            ctrl_start_addr <= cur.start_line;
            ctrl_end_addr   <= cur.end_line;
            ctrl_reload     <= 1'b1;
            state           <= LOAD;
          end
        end
        LOAD: begin
          cnt   <= '0;
          state <= abort ? IDLE : RUN;
        end
        RUN: begin
          if (abort) begin
            cmp_valid <= 1'b1;
            cmp_rw    <= cur.rw;
            cmp_beats <= beat ? cnt_inc : cnt;
            cmp_err   <= 1'b1;
            state     <= DONE;
          end else if (beat) begin
            cnt <= cnt_inc;
            // Clean finish only when the final expected beat carries tlast.
            if (cnt_inc == exp_beats || beat_last) begin
              cmp_valid <= 1'b1;
              cmp_rw    <= cur.rw;
              cmp_beats <= cnt_inc;
              cmp_err   <= !((cnt_inc == exp_beats) && beat_last);
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (cmp_ready) begin
            cmp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_xfer_scheduler.sv
// Scoreboard bench for bram_xfer_scheduler with a behavioural adapter that streams beats after each reload.
module tb_bram_xfer_scheduler;

  localparam int ADDR_W = 12;
  localparam int CNT_W  = 18;
  localparam int BPL    = 36;

  logic              aclk = 1'b0;
  logic              areset = 1'b1;
  logic              desc_valid;
  logic              desc_ready;
  logic              desc_rw;
  logic [ADDR_W-1:0] desc_start;
  logic [ADDR_W-1:0] desc_end;
  logic              ctrl_rw;
  logic              ctrl_reload;
  logic [ADDR_W-1:0] ctrl_start_addr;
  logic [ADDR_W-1:0] ctrl_end_addr;
  logic              beat;
  logic              beat_last;
  logic              abort;
  logic              cmp_valid;
  logic              cmp_ready;
  logic              cmp_rw;
  logic [CNT_W-1:0]  cmp_beats;
  logic              cmp_err;
  logic              busy;

  typedef struct {
    bit rw;
    int s;
    int e;
    int n;
    int last_at;
    bit do_abort;
  } plan_t;

  typedef struct {
    bit rw;
    int beats;
    bit err;
  } rec_t;

  plan_t plan_q[$];
  rec_t  exp_q[$];
  int    n_tests  = 0;
  int    n_fail   = 0;
  int    n_done   = 0;
  int    n_reload = 0;

  always #5 aclk = ~aclk;

  bram_xfer_scheduler dut (
    .aclk            (aclk),
    .areset          (areset),
    .desc_valid      (desc_valid),
    .desc_ready      (desc_ready),
    .desc_rw         (desc_rw),
    .desc_start      (desc_start),
    .desc_end        (desc_end),
    .ctrl_rw         (ctrl_rw),
    .ctrl_reload     (ctrl_reload),
    .ctrl_start_addr (ctrl_start_addr),
    .ctrl_end_addr   (ctrl_end_addr),
    .beat            (beat),
    .beat_last       (beat_last),
    .abort           (abort),
    .cmp_valid       (cmp_valid),
    .cmp_ready       (cmp_ready),
    .cmp_rw          (cmp_rw),
    .cmp_beats       (cmp_beats),
    .cmp_err         (cmp_err),
    .busy            (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic push_desc(input bit rw, input int s, input int e);
    int k;
    k          = 0;
    desc_valid = 1'b1;
    desc_rw    = rw;
    desc_start = ADDR_W'(s);
    desc_end   = ADDR_W'(e);
    while (!desc_ready && k < 500) begin
      tick();
      k++;
    end
    if (!desc_ready) chk("push_timeout", 0, 1);
    tick();
    desc_valid = 1'b0;
  endtask

  task automatic xfer(input bit rw, input int s, input int e, input int n, input int last_at,
                      input bit do_abort, input int exp_beats, input bit exp_err);
    plan_t p;
    rec_t  r;
    p = '{rw: rw, s: s, e: e, n: n, last_at: last_at, do_abort: do_abort};
    r = '{rw: rw, beats: exp_beats, err: exp_err};
    plan_q.push_back(p);
    exp_q.push_back(r);
    push_desc(rw, s, e);
  endtask

  task automatic wait_done(input int target, input string tag);
    int k;
    k = 0;
    while (n_done < target && k < 3000) begin
      tick();
      k++;
    end
    chk(tag, n_done, target);
  endtask

  // Adapter model: checks programmed controls at each reload, then streams the planned beats.
  initial begin : adapter
    plan_t p;
    forever begin
      @(posedge aclk);
      #1;
      if (ctrl_reload && !areset) begin
        n_reload++;
        if (plan_q.size() == 0) begin
          chk("reload_unplanned", 1, 0);
        end else begin
          p = plan_q.pop_front();
          chk("ctrl_rw", ctrl_rw, p.rw);
          chk("ctrl_start", ctrl_start_addr, p.s);
          chk("ctrl_end", ctrl_end_addr, p.e);
          @(posedge aclk);
          #1;
          for (int i = 1; i <= p.n; i++) begin
            beat      = 1'b1;
            beat_last = (i == p.last_at);
            @(posedge aclk);
            #1;
          end
          beat      = 1'b0;
          beat_last = 1'b0;
          if (p.do_abort) begin
            abort = 1'b1;
            @(posedge aclk);
            #1;
            abort = 1'b0;
          end
        end
      end
    end
  end

  // Completion monitor: pops the scoreboard on every accepted record.
  always @(negedge aclk) begin
    if (!areset && cmp_valid && cmp_ready) begin : mon
      rec_t r;
      if (exp_q.size() == 0) begin
        chk("cmp_unexpected", 1, 0);
      end else begin
        r = exp_q.pop_front();
        chk("cmp_rw", cmp_rw, r.rw);
        chk("cmp_beats", cmp_beats, r.beats);
        chk("cmp_err", cmp_err, r.err);
      end
      n_done++;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, done %0d", n_done);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int lat;
    int k;
    int rl;
    int lines;
    desc_valid = 1'b0;
    desc_rw    = 1'b0;
    desc_start = '0;
    desc_end   = '0;
    beat       = 1'b0;
    beat_last  = 1'b0;
    abort      = 1'b0;
    cmp_ready  = 1'b1;

    #12;
    chk("rst_desc_ready", desc_ready, 1);
    chk("rst_ctrl_rw", ctrl_rw, 1);
    chk("rst_ctrl_reload", ctrl_reload, 0);
    chk("rst_ctrl_start", ctrl_start_addr, 0);
    chk("rst_ctrl_end", ctrl_end_addr, 0);
    chk("rst_cmp_valid", cmp_valid, 0);
    chk("rst_cmp_beats", cmp_beats, 0);
    chk("rst_cmp_err", cmp_err, 0);
    chk("rst_busy", busy, 0);
    @(negedge aclk);
    areset = 1'b0;
    tick();

    // Full 9-line write, reload latency measured from the push cycle
    plan_q.push_back('{rw: 1'b1, s: 0, e: 8, n: 324, last_at: 324, do_abort: 1'b0});
    exp_q.push_back('{rw: 1'b1, beats: 324, err: 1'b0});
    desc_valid = 1'b1;
    desc_rw    = 1'b1;
    desc_start = ADDR_W'(0);
    desc_end   = ADDR_W'(8);
    lat        = 0;
    do begin
      tick();
      desc_valid = 1'b0;
      lat++;
    end while (!ctrl_reload && lat < 10);
    chk("reload_latency", lat, 3);
    wait_done(1, "t1_done");

    // Read held by cmp_ready low; queued follower must not reload meanwhile
    cmp_ready = 1'b0;
    xfer(1'b0, 0, 1, 72, 72, 1'b0, 72, 1'b0);
    xfer(1'b1, 3, 3, 36, 36, 1'b0, 36, 1'b0);
    k = 0;
    while (!cmp_valid && k < 1000) begin
      tick();
      k++;
    end
    chk("t2_valid_seen", cmp_valid, 1);
    rl = n_reload;
    repeat (5) begin
      tick();
      chk("t2_hold_valid", cmp_valid, 1);
      chk("t2_hold_beats", cmp_beats, 72);
      chk("t2_hold_rw", cmp_rw, 0);
    end
    chk("t2_no_reload_held", n_reload, rl);
    cmp_ready = 1'b1;
    wait_done(3, "t2_done");

    // Short write: tlast on beat 40 of 72
    xfer(1'b1, 0, 1, 40, 40, 1'b0, 40, 1'b1);
    wait_done(4, "t3_done");

    // Inverted range is rejected without touching the adapter
    rl = n_reload;
    exp_q.push_back('{rw: 1'b1, beats: 0, err: 1'b1});
    push_desc(1'b1, 10, 3);
    wait_done(5, "t4_bad_done");
    chk("t4_no_reload", n_reload, rl);
    xfer(1'b0, 2, 2, 36, 36, 1'b0, 36, 1'b0);
    wait_done(6, "t4_next_done");
    chk("t4_next_reload", n_reload, rl + 1);

    // Five back-to-back descriptors through a depth-4 queue
    for (int d = 0; d < 5; d++) begin
      lines = 1 + (d % 2);
      xfer(bit'(d % 2), d * 4, d * 4 + lines - 1, lines * BPL, lines * BPL, 1'b0,
           lines * BPL, 1'b0);
    end
    chk("t5_ready_full", desc_ready, 0);
    wait_done(11, "t5_done");

    // Abort after 100 beats with two descriptors queued behind
    xfer(1'b1, 0, 8, 100, 0, 1'b1, 100, 1'b1);
    push_desc(1'b1, 1, 2);
    push_desc(1'b0, 3, 4);
    wait_done(12, "t6_done");
    tick();
    chk("t6_busy", busy, 0);
    chk("t6_desc_ready", desc_ready, 1);
    rl = n_reload;
    repeat (20) tick();
    chk("t6_flushed", n_reload, rl);
    chk("t6_no_extra_cmp", n_done, 12);

    // Reset in the middle of a read transfer
    plan_q.push_back('{rw: 1'b0, s: 0, e: 8, n: 50, last_at: 0, do_abort: 1'b0});
    push_desc(1'b0, 0, 8);
    repeat (60) tick();
    chk("t7_pre_busy", busy, 1);
    chk("t7_pre_ctrl_end", ctrl_end_addr, 8);
    #2;
    areset = 1'b1;
    #1;
    chk("t7_rst_ctrl_rw", ctrl_rw, 1);
    chk("t7_rst_ctrl_start", ctrl_start_addr, 0);
    chk("t7_rst_ctrl_end", ctrl_end_addr, 0);
    chk("t7_rst_reload", ctrl_reload, 0);
    chk("t7_rst_busy", busy, 0);
    chk("t7_rst_cmp_valid", cmp_valid, 0);
    chk("t7_rst_cmp_beats", cmp_beats, 0);
    chk("t7_rst_cmp_err", cmp_err, 0);
    chk("t7_rst_desc_ready", desc_ready, 1);
    @(negedge aclk);
    areset = 1'b0;
    repeat (10) tick();
    chk("t7_no_cmp", n_done, 12);

    chk("exp_q_empty", exp_q.size(), 0);
    chk("plan_q_empty", plan_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
